// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem read, PC advance/redirect, IR handshake to decode.
// Define FETCH_PREFETCH_EN to add a one-entry prefetch buffer for back-to-back issue.
module instruction_fetch #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HOLD} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_ir_valid;
  logic [DATA_W-1:0] r_ir_data;
  logic [ADDR_W-1:0] r_ir_pc;

  logic w_redirect;
  logic w_accept;
  logic w_ir_hs;
  logic w_pf_issue;
  logic w_pf_out;
  logic w_outstanding;

`ifdef FETCH_PREFETCH_EN
  logic              r_pf_out;
  logic              r_pbuf_valid;
  logic [DATA_W-1:0] r_pbuf_data;
  logic [ADDR_W-1:0] r_pbuf_pc;

  // Prefetch only while decode holds the IR and nothing else is in flight or buffered.
  assign w_pf_issue = (r_state == HOLD) && !halt && !r_pf_out && !r_pbuf_valid;
  assign w_pf_out   = r_pf_out;
`else
  assign w_pf_issue = 1'b0;
  assign w_pf_out   = 1'b0;
`endif

  // Redirect wins over every handshake in the cycle it is raised.
  assign w_redirect     = reset && redirect_valid;
  assign imem_req_valid = reset && !redirect_valid && ((r_state == REQ) || w_pf_issue);
  assign imem_req_addr  = imem_req_valid ? pc : '0;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign pc_inc         = w_accept;
  assign pc_load        = w_redirect;
  assign pc_target      = w_redirect ? redirect_addr : '0;
  assign w_ir_hs        = r_ir_valid && ir_ready;
  assign w_outstanding  = (r_state == WAIT) || (r_state == DRAIN) || w_pf_out;

  assign ir_valid = r_ir_valid;
  assign ir_data  = r_ir_data;
  assign ir_pc    = r_ir_pc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_req_addr <= '0;
      r_ir_valid <= 1'b0;
      r_ir_data  <= '0;
      r_ir_pc    <= '0;
`ifdef FETCH_PREFETCH_EN
      r_pf_out     <= 1'b0;
      r_pbuf_valid <= 1'b0;
      r_pbuf_data  <= '0;
      r_pbuf_pc    <= '0;
`endif
    end else if (redirect_valid) begin
      r_ir_valid <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      r_pf_out     <= 1'b0;
      r_pbuf_valid <= 1'b0;
`endif
      // A response landing in the redirect cycle already retires the stale request.
      if (w_outstanding && !imem_rsp_valid) r_state <= DRAIN;
      else                                  r_state <= halt ? IDLE : REQ;
    end else begin
      if (w_accept) r_req_addr <= pc;
      case (r_state)
        IDLE:  if (!halt) r_state <= REQ;
        REQ:   if (w_accept) r_state <= WAIT;
        WAIT: begin
          if (imem_rsp_valid) begin
            r_ir_data  <= imem_rsp_data;
            r_ir_pc    <= r_req_addr;
            r_ir_valid <= 1'b1;
            r_state    <= HOLD;
          end
        end
        DRAIN: if (imem_rsp_valid) r_state <= halt ? IDLE : REQ;
        HOLD: begin
`ifdef FETCH_PREFETCH_EN
          if (w_accept) r_pf_out <= 1'b1;
          if (w_ir_hs) begin
            if (r_pbuf_valid) begin
              r_ir_data    <= r_pbuf_data;
              r_ir_pc      <= r_pbuf_pc;
              r_pbuf_valid <= 1'b0;
            end else if (r_pf_out && imem_rsp_valid) begin
              r_ir_data <= imem_rsp_data;
              r_ir_pc   <= r_req_addr;
              r_pf_out  <= 1'b0;
            end else if (r_pf_out || w_accept) begin
              // Prefetch still in flight: let WAIT land it straight into the IR.
              r_ir_valid <= 1'b0;
              r_pf_out   <= 1'b0;
              r_state    <= WAIT;
            end else begin
              r_ir_valid <= 1'b0;
              r_state    <= halt ? IDLE : REQ;
            end
          end else if (r_pf_out && imem_rsp_valid) begin
            r_pbuf_data  <= imem_rsp_data;
            r_pbuf_pc    <= r_req_addr;
            r_pbuf_valid <= 1'b1;
            r_pf_out     <= 1'b0;
          end
`else
          if (w_ir_hs) begin
            r_ir_valid <= 1'b0;
            r_state    <= halt ? IDLE : REQ;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: environment PC + memory model, scoreboard of expected IR deliveries.
`timescale 1ns/1ps
module tb_instruction_fetch;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc;
  logic          pc_inc, pc_load;
  logic [AW-1:0] pc_target;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          halt;
  logic          imem_req_valid, imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;
  logic          ir_valid, ir_ready;
  logic [DW-1:0] ir_data;
  logic [AW-1:0] ir_pc;

  instruction_fetch #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_inc(pc_inc), .pc_load(pc_load),
    .pc_target(pc_target), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .halt(halt), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir_data(ir_data), .ir_pc(ir_pc)
  );

  always #5 clk = ~clk;

  // Program counter owned by the environment.
  always @(posedge clk) begin
    if (!reset)       pc <= 16'h0010;
    else if (pc_load) pc <= pc_target;
    else if (pc_inc)  pc <= pc + 16'd1;
  end

  int          checks = 0;
  int          errors = 0;
  int          deliveries = 0;
  exp_t        exp_q[$];
  logic [AW-1:0] exp_addr;
  int unsigned ready_pct = 100, irr_pct = 100, dly_min = 1, dly_max = 1;
  logic        halt_knob = 1'b0;
  bit          mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [AW-1:0] mem_addr;
  bit          last_acc = 1'b0;
  logic [AW-1:0] last_acc_addr;

  // Memory contents: address 0x0000 holds 0xA001, address 0xAC7E holds 0xDEAD.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'hA001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus plus per-cycle protocol checks and scoreboard pushes.
  task automatic step(input bit redir, input logic [AW-1:0] raddr);
    bit acc_now;
    @(negedge clk);
    redirect_valid = redir;
    redirect_addr  = redir ? raddr : 16'($urandom);
    halt           = halt_knob;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    ir_ready       = !redir && ($urandom_range(99) < irr_pct);
    if (mem_pend && mem_cnt == 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_addr);
      mem_pend       = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 16'($urandom);
      if (mem_pend) mem_cnt--;
    end
    #2;
    acc_now = imem_req_valid && imem_req_ready;
    chk("pc_inc", 32'(pc_inc), 32'(acc_now));
    chk("pc_load", 32'(pc_load), 32'(redir));
    if (redir) begin
      chk("pc_target", 32'(pc_target), 32'(raddr));
      chk("req_masked", 32'(imem_req_valid), 32'(0));
    end
    if (acc_now) begin
      chk("req_addr", 32'(imem_req_addr), 32'(exp_addr));
      chk("one_outstanding", 32'(mem_pend), 32'(0));
      mem_pend = 1'b1;
      mem_cnt  = int'($urandom_range(dly_max, dly_min));
      mem_addr = imem_req_addr;
      exp_q.push_back('{pc: exp_addr, data: mem_word(exp_addr)});
      exp_addr = exp_addr + 16'd1;
    end
    // Everything fetched but not yet consumed by decode is squashed.
    if (redir) begin
      exp_q.delete();
      exp_addr = raddr;
    end
    last_acc      = acc_now;
    last_acc_addr = imem_req_addr;
  endtask

  task automatic wait_acc(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b0, 16'h0000);
      got = last_acc;
    end
    chk({name, "_timeout"}, 32'(got), 32'(1));
  endtask

  // Monitor: compare every decode handshake against the oldest expected instruction.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (reset === 1'b1 && ir_valid === 1'b1) begin
        checks++;
        if (ir_data == 16'hDEAD) begin
          errors++;
          $display("FAIL no_stale: ir_data=%h is the squashed word", ir_data);
        end
        if (ir_ready) begin
          deliveries++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ir_unexpected: got pc %h data %h, expected no delivery", ir_pc, ir_data);
          end else begin
            e = exp_q.pop_front();
            chk("ir_data", 32'(ir_data), 32'(e.data));
            chk("ir_pc", 32'(ir_pc), 32'(e.pc));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int  d0, req_cnt;
    bit  got, saw_wrap;
    logic [DW-1:0] hold_d;
    logic [AW-1:0] hold_p;

    reset = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; halt = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; ir_ready = 1'b0;

    // Reset held for three edges.
    repeat (3) @(negedge clk);
    #2;
    chk("rst_pc_inc", 32'(pc_inc), 32'(0));
    chk("rst_pc_load", 32'(pc_load), 32'(0));
    chk("rst_pc_target", 32'(pc_target), 32'(0));
    chk("rst_req_valid", 32'(imem_req_valid), 32'(0));
    chk("rst_req_addr", 32'(imem_req_addr), 32'(0));
    chk("rst_ir_valid", 32'(ir_valid), 32'(0));
    chk("rst_ir_data", 32'(ir_data), 32'(0));
    chk("rst_ir_pc", 32'(ir_pc), 32'(0));
    reset    = 1'b1;
    exp_addr = 16'h0010;

    // Redirect to 0x0000 while REQ sees ready: no handshake, no increment.
    step(1'b1, 16'h0000);
    chk("redir_no_inc", 32'(pc_inc), 32'(0));

    // Straight-line fetch with 1-cycle memory.
    step(1'b0, 16'h0000);
    chk("first_acc", 32'(last_acc), 32'(1));
    chk("first_addr", 32'(last_acc_addr), 32'(16'h0000));
    step(1'b0, 16'h0000);
    chk("lat1_ir_valid", 32'(ir_valid), 32'(0));
    step(1'b0, 16'h0000);
    chk("lat2_ir_valid", 32'(ir_valid), 32'(1));
    chk("first_ir_data", 32'(ir_data), 32'(16'hA001));
    chk("first_ir_pc", 32'(ir_pc), 32'(16'h0000));
    d0 = deliveries;
    repeat (30) step(1'b0, 16'h0000);
`ifndef FETCH_PREFETCH_EN
    chk("throughput", 32'(deliveries - d0), 32'(10));
`endif

    // Decode stall.
    irr_pct = 0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(1'b0, 16'h0000);
      got = ir_valid;
    end
    chk("stall_ir_valid", 32'(got), 32'(1));
    hold_d  = ir_data;
    hold_p  = ir_pc;
    req_cnt = int'(last_acc);
    repeat (5) begin
      step(1'b0, 16'h0000);
      req_cnt += int'(last_acc);
      chk("stall_valid", 32'(ir_valid), 32'(1));
      chk("stall_data", 32'(ir_data), 32'(hold_d));
      chk("stall_pc", 32'(ir_pc), 32'(hold_p));
    end
`ifdef FETCH_PREFETCH_EN
    chk("stall_reqs", 32'(req_cnt), 32'(1));
`else
    chk("stall_reqs", 32'(req_cnt), 32'(0));
`endif
    irr_pct = 100;

    // Redirect in WAIT: fetch of 0xAC7E (0xDEAD) is squashed, next fetch is 0x0200.
    step(1'b1, 16'hAC7E);
    dly_min = 2; dly_max = 2;
    wait_acc("acc_ac7e");
    chk("acc_ac7e_addr", 32'(last_acc_addr), 32'(16'hAC7E));
    dly_min = 1; dly_max = 1;
    step(1'b1, 16'h0200);
    step(1'b0, 16'h0000);
    step(1'b0, 16'h0000);
    chk("drain_no_ir", 32'(ir_valid), 32'(0));
    if (!last_acc) wait_acc("acc_0200");
    chk("acc_0200_addr", 32'(last_acc_addr), 32'(16'h0200));

    // Halt raised in WAIT: the word still lands, then no more requests.
    wait_acc("acc_halt");
    halt_knob = 1'b1;
    d0 = deliveries;
    repeat (8) begin
      step(1'b0, 16'h0000);
      chk("halt_no_req", 32'(imem_req_valid), 32'(0));
    end
    @(posedge clk);
    chk("halt_delivered", 32'(deliveries - d0), 32'(1));
    halt_knob = 1'b0;
    wait_acc("acc_unhalt");

    // PC wrap passes through unmodified.
    step(1'b1, 16'hFFFE);
    saw_wrap = 1'b0;
    repeat (12) begin
      step(1'b0, 16'h0000);
      if (last_acc && last_acc_addr == 16'h0000) saw_wrap = 1'b1;
    end
    chk("wrap_seen", 32'(saw_wrap), 32'(1));

    // Randomized traffic.
    ready_pct = 70; irr_pct = 60; dly_min = 1; dly_max = 3;
    d0 = deliveries;
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] ra;
      halt_knob = ($urandom_range(99) < 10);
      ra = ($urandom_range(99) < 20) ? 16'($urandom_range(16'hFFFF, 16'hFFFC))
                                     : 16'($urandom_range(16'h0FFF, 0));
      step($urandom_range(99) < 5, ra);
    end
    chk("random_progress", 32'(deliveries - d0 > 200), 32'(1));

    // Quiesce and confirm nothing is left behind.
    halt_knob = 1'b1; ready_pct = 100; irr_pct = 100; dly_min = 1; dly_max = 1;
    repeat (20) step(1'b0, 16'h0000);
    @(posedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'(0));
    chk("final_ir_valid", 32'(ir_valid), 32'(0));
    chk("final_mem_idle", 32'(mem_pend), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
